// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - opcode constants, field positions, fetch states and helpers
package fetch_stage_pkg;

   localparam int INSTR_W  = 16;
   localparam int OPC_W    = 9;
   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 7;
   localparam int RDST_MSB = 6;
   localparam int RDST_LSB = 4;
   localparam int RSRC_MSB = 3;
   localparam int RSRC_LSB = 1;

   localparam logic [OPC_W-1:0] OPC_NOP = 9'h000;
   localparam logic [OPC_W-1:0] OPC_LDM = 9'h0C2;
   localparam logic [OPC_W-1:0] OPC_LDD = 9'h0C3;
   localparam logic [OPC_W-1:0] OPC_STD = 9'h0C4;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_FETCH,
      ST_FETCH_IMM
   } fetch_state_t;

   // Instructions whose second word is an immediate/address.
   function automatic logic is_two_word(input logic [OPC_W-1:0] opcode);
      return (opcode == OPC_LDM) || (opcode == OPC_LDD) || (opcode == OPC_STD);
   endfunction

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, one/two-word assembly, IF/ID register
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int RESET_VEC_ADDR = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [ADDR_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0]   imem_data,
   input  logic                 stall,
   input  logic                 redirect_valid,
   input  logic [ADDR_W-1:0]    redirect_pc,
   output logic                 if_id_valid,
   output logic [INSTR_W-1:0]   if_id_instr,
   output logic [OPC_W-1:0]     if_id_opcode,
   output logic [INSTR_W-1:0]   if_id_imm,
   output logic [ADDR_W-1:0]    if_id_pc_next
);

   localparam logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

   fetch_state_t        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W-1:0]   pc_inc;
   logic [INSTR_W-1:0]  hold_instr_q;
   logic                two_word;

   assign pc_inc       = pc_q + PC_ONE;
   assign two_word     = is_two_word(imem_data[OPC_MSB:OPC_LSB]);
   assign if_id_opcode = if_id_instr[OPC_MSB:OPC_LSB];

   always_comb begin
      state_d   = state_q;
      imem_addr = pc_q;
      case (state_q)
         ST_BOOT: begin
            imem_addr = RESET_VEC;
            state_d   = ST_FETCH;
         end
         ST_FETCH: begin
            if (redirect_valid)       state_d = ST_FETCH;
            else if (!stall && two_word) state_d = ST_FETCH_IMM;
         end
         ST_FETCH_IMM: begin
            if (redirect_valid || !stall) state_d = ST_FETCH;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_BOOT;
         pc_q          <= '0;
         hold_instr_q  <= '0;
         if_id_valid   <= 1'b0;
         if_id_instr   <= '0;
         if_id_imm     <= '0;
         if_id_pc_next <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_BOOT) begin
            pc_q <= imem_data[ADDR_W-1:0];
         end else if (redirect_valid) begin
            pc_q          <= redirect_pc;
            hold_instr_q  <= '0;
            if_id_valid   <= 1'b0;
            if_id_instr   <= '0;
            if_id_imm     <= '0;
            if_id_pc_next <= '0;
         end else if (!stall) begin
            pc_q <= pc_inc;
            if (state_q == ST_FETCH_IMM) begin
               if_id_valid   <= 1'b1;
               if_id_instr   <= hold_instr_q;
               if_id_imm     <= imem_data;
               if_id_pc_next <= pc_inc;
            end else if (two_word) begin
               // First word is parked; IF/ID carries a bubble while the immediate is read.
               hold_instr_q  <= imem_data;
               if_id_valid   <= 1'b0;
               if_id_instr   <= '0;
               if_id_imm     <= '0;
               if_id_pc_next <= '0;
            end else begin
               if_id_valid   <= 1'b1;
               if_id_instr   <= imem_data;
               if_id_imm     <= '0;
               if_id_pc_next <= pc_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0;
   logic        if_id_valid;
   logic [15:0] if_id_instr;
   logic [8:0]  if_id_opcode;
   logic [15:0] if_id_imm;
   logic [15:0] if_id_pc_next;

   logic [15:0] mem [0:65535];
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        stall;
      logic        rv;
      logic [15:0] rpc;
      logic        v;
      logic [15:0] instr;
      logic [15:0] imm;
      logic [15:0] pcn;
      logic [15:0] addr;
   } vec_t;

   vec_t vecs [19];

   assign imem_data = mem[imem_addr];

   fetch_stage #(.ADDR_W(16), .RESET_VEC_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode),
      .if_id_imm(if_id_imm), .if_id_pc_next(if_id_pc_next)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [15:0] instr,
                          input logic [15:0] imm, input logic [15:0] pcn, input logic [15:0] addr);
      chk({tag, ".valid"},   {31'b0, if_id_valid}, {31'b0, v});
      chk({tag, ".instr"},   {16'b0, if_id_instr}, {16'b0, instr});
      chk({tag, ".opcode"},  {23'b0, if_id_opcode}, {23'b0, instr[15:7]});
      chk({tag, ".imm"},     {16'b0, if_id_imm}, {16'b0, imm});
      chk({tag, ".pc_next"}, {16'b0, if_id_pc_next}, {16'b0, pcn});
      chk({tag, ".addr"},    {16'b0, imem_addr}, {16'b0, addr});
   endtask

   function automatic vec_t mk(logic s, logic rv, logic [15:0] rpc, logic v,
                               logic [15:0] instr, logic [15:0] imm, logic [15:0] pcn, logic [15:0] addr);
      vec_t r;
      r.stall = s; r.rv = rv; r.rpc = rpc; r.v = v;
      r.instr = instr; r.imm = imm; r.pcn = pcn; r.addr = addr;
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[16'h0000] = 16'h0010;
      mem[16'h0001] = 16'h0C00;
      mem[16'h0010] = 16'h2000;   // NOT
      mem[16'h0011] = 16'h6100;   // LDM
      mem[16'h0012] = 16'hBEEF;
      mem[16'h0013] = 16'h2412;
      mem[16'h0014] = 16'h0A02;
      mem[16'h0015] = 16'h1234;
      mem[16'h0016] = 16'h6200;   // STD
      mem[16'h0017] = 16'h0055;
      mem[16'h0040] = 16'h3C0E;
      mem[16'h0041] = 16'h6180;   // LDD
      mem[16'h0042] = 16'hCAFE;
      mem[16'hFFFF] = 16'h6100;   // LDM at last address

      //                  stall rv  rpc       v  instr     imm       pc_next   addr
      vecs[0]  = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010); // boot
      vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h2000, 16'h0000, 16'h0011, 16'h0011);
      vecs[2]  = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0012);
      vecs[3]  = mk(0, 0, 16'h0000, 1, 16'h6100, 16'hBEEF, 16'h0013, 16'h0013);
      vecs[4]  = mk(1, 0, 16'h0000, 1, 16'h6100, 16'hBEEF, 16'h0013, 16'h0013);
      vecs[5]  = mk(1, 0, 16'h0000, 1, 16'h6100, 16'hBEEF, 16'h0013, 16'h0013);
      vecs[6]  = mk(1, 0, 16'h0000, 1, 16'h6100, 16'hBEEF, 16'h0013, 16'h0013);
      vecs[7]  = mk(0, 0, 16'h0000, 1, 16'h2412, 16'h0000, 16'h0014, 16'h0014);
      vecs[8]  = mk(0, 0, 16'h0000, 1, 16'h0A02, 16'h0000, 16'h0015, 16'h0015);
      vecs[9]  = mk(0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0016, 16'h0016);
      vecs[10] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0017);
      vecs[11] = mk(1, 1, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0040); // redirect+stall in FETCH_IMM
      vecs[12] = mk(0, 0, 16'h0000, 1, 16'h3C0E, 16'h0000, 16'h0041, 16'h0041);
      vecs[13] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042);
      vecs[14] = mk(0, 0, 16'h0000, 1, 16'h6180, 16'hCAFE, 16'h0043, 16'h0043);
      vecs[15] = mk(0, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
      vecs[16] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      vecs[17] = mk(0, 0, 16'h0000, 1, 16'h6100, 16'h0010, 16'h0001, 16'h0001); // wrap
      vecs[18] = mk(0, 0, 16'h0000, 1, 16'h0C00, 16'h0000, 16'h0002, 16'h0002);

      #12;
      chk_out("reset", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         stall          = vecs[i].stall;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         @(posedge clk); #1;
         chk_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].instr, vecs[i].imm,
                 vecs[i].pcn, vecs[i].addr);
      end

      // Reach FETCH_IMM of the STD at 0x16, then pulse reset mid-cycle.
      stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0016;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      chk_out("rd_std", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0016);
      @(posedge clk); #1;
      chk_out("std_imm", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0017);
      #2 rst_n = 1'b0;
      #1 chk_out("async_rst", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      @(posedge clk); #1;
      chk_out("rst_held", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      rst_n = 1'b1;
      // stall/redirect must not disturb the boot cycle
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
      @(posedge clk); #1;
      stall = 1'b0; redirect_valid = 1'b0;
      chk_out("reboot", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010);
      @(posedge clk); #1;
      chk_out("reboot_first", 1, 16'h2000, 16'h0000, 16'h0011, 16'h0011);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline: owns the PC, reads 16-bit words from instruction memory, assembles one- and two-word instructions, and drives the IF/ID register whose opcode field feeds the control unit. It boots from a reset vector stored in memory, honours pipeline stalls, and accepts branch/call/return redirects from later stages.

## Interface
Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- RESET_VEC_ADDR, 0, memory address holding the boot PC.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  instruction-memory address (combinational from state/PC).
- imem_data  in  16  word at imem_addr, valid in the same cycle.
- stall  in  1  hazard unit: freeze PC, state and IF/ID outputs.
- redirect_valid  in  1  taken branch/CALL/RET from a later stage.
- redirect_pc  in  ADDR_W  target PC.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  16  instruction word; [15:7] opcode, [6:4] Rdst, [3:1] Rsrc, [0] reserved.
- if_id_opcode  out  9  copy of if_id_instr[15:7], routed to the control unit.
- if_id_imm  out  16  second word of a two-word instruction, else 0.
- if_id_pc_next  out  ADDR_W  address following the whole instruction (CALL return address).

## Operation
- Two-word opcodes: LDM 011_00010, LDD 011_00011, STD 011_00100. All others are one word.
- States: BOOT, FETCH, FETCH_IMM.
- BOOT: imem_addr = RESET_VEC_ADDR; at the edge PC <= imem_data[ADDR_W-1:0], go to FETCH, IF/ID stays a bubble. stall and redirect are ignored in BOOT.
- FETCH: imem_addr = PC.
  - One-word: IF/ID <= {valid=1, instr, imm=0, pc_next=PC+1}; PC <= PC+1.
  - Two-word: hold_instr <= imem_data; PC <= PC+1; go to FETCH_IMM; IF/ID <= bubble.
- FETCH_IMM: imem_addr = PC. IF/ID <= {valid=1, hold_instr, imm=imem_data, pc_next=PC+1}; PC <= PC+1; go to FETCH.
- Bubble means valid=0, instr=0 (opcode 0 = NOP), imm=0, pc_next=0.
- Priority per edge, in BOOT, then redirect, then stall, then normal.
- redirect_valid (FETCH or FETCH_IMM): PC <= redirect_pc, state <= FETCH, hold_instr discarded, IF/ID <= bubble.
- stall (no redirect): PC, state, hold_instr and all IF/ID outputs keep their values.
- PC arithmetic wraps modulo 2^ADDR_W. A two-word instruction at the last address takes its immediate from address 0, and pc_next = 1.

## Timing
- Reset, asynchronous: state=BOOT, PC=0, hold_instr=0, IF/ID = bubble (all outputs 0). imem_addr = RESET_VEC_ADDR during reset.
- Boot takes 1 cycle after rst_n deasserts. The first instruction appears at IF/ID 2 edges after release.
- One-word instruction: in IF/ID 1 edge after being addressed. Throughput is 1 per cycle.
- Two-word instruction: 2 edges, with exactly one bubble before it.
- Redirect: target instruction in IF/ID 2 edges after the redirect edge, or 3 edges if the target is two-word.
- Reset asserted mid-operation aborts immediately and returns to BOOT. A pending FETCH_IMM is lost.

## Structure
- Shared package, also used by the control unit: 9-bit opcode constants, the instruction field positions, the state enum {BOOT, FETCH, FETCH_IMM}, and the function is_two_word(opcode).
- No sub-module. The PC register, incrementer and IF/ID register stay in one always_ff, with one combinational block for imem_addr and next-state logic.

## Test plan
- Reset then release, with mem[0]=0x0010 and mem[0x10]=NOT (0x2000) -> BOOT 1 cycle; IF/ID shows 0x2000, valid=1, pc_next=0x11.
- LDM at 0x10 (0x6100), mem[0x11]=0xBEEF -> one bubble, then instr=0x6100, imm=0xBEEF, pc_next=0x12; next fetch at 0x12.
- stall held 3 cycles mid-stream -> PC and IF/ID unchanged for 3 cycles, then normal progression resumes with no instruction lost or duplicated.
- redirect_valid with redirect_pc=0x40 asserted in FETCH_IMM of an STD -> STD dropped, bubble, then mem[0x40] instruction; redirect with stall in the same cycle -> redirect wins.
- Two-word instruction at 0xFFFF, ADDR_W=16 -> immediate read from 0x0000, pc_next=0x0001.
- rst_n pulsed low during FETCH_IMM -> outputs 0 asynchronously, then re-boot from RESET_VEC_ADDR.
